// File: rtl/exec_unit_mc.sv
// exec_unit_mc: multicycle execute unit with single-cycle ALU/shift/compare ops and
// iterative signed multiply/divide behind a start/done handshake.
module exec_unit_mc #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             overflow,
    output logic             zero,
    output logic             div_zero,
    output logic             eq,
    output logic             gt
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    state_t state, state_n;
    logic [SHW:0] cnt;
    logic [WIDTH-1:0] acc, lo, mag;
    logic sign_a, sign_b, is_div, ovf_p, eq_p, gt_p;
    logic idle, take, op_mul, op_div, div0, rsv, last, neg, alu_ovf, cmp_gt;
    logic [WIDTH-1:0] abs_a, abs_b, sum, dif, alu, step_hi, step_lo, fin_lo, fin_hi;
    logic [WIDTH:0] mul_sum, r_sh, r_dif;
    logic [2*WIDTH-1:0] prod, prod_s;

    assign idle   = state == IDLE || state == FIN;
    assign busy   = state == MUL || state == DIV;
    assign take   = idle && start;
    assign op_mul = op == 4'd11;
    assign op_div = op == 4'd12 && src_b != '0;
    assign div0   = op == 4'd12 && src_b == '0;
    assign rsv    = op >= 4'd14;
    assign abs_a  = src_a[WIDTH-1] ? -src_a : src_a;
    assign abs_b  = src_b[WIDTH-1] ? -src_b : src_b;
    assign sum    = src_a + src_b;
    assign dif    = src_a - src_b;
    assign cmp_gt = $signed(src_a) > $signed(src_b);

    always_comb begin
        alu = '0;
        case (op)
            4'd0:    alu = sum;
            4'd1:    alu = dif;
            4'd2:    alu = src_a & src_b;
            4'd3:    alu = src_a | src_b;
            4'd4:    alu = src_a ^ src_b;
            4'd5:    alu = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            4'd6:    alu = src_b << shamt;
            4'd7:    alu = src_b >> shamt;
            4'd8:    alu = $signed(src_b) >>> shamt;
            4'd9:    alu = src_b << src_a[SHW-1:0];
            4'd10:   alu = $signed(src_b) >>> src_a[SHW-1:0];
            4'd12:   alu = '1;
            4'd13:   alu = src_a;
            default: alu = '0;
        endcase
    end

    assign alu_ovf = op == 4'd0 ? (src_a[WIDTH-1] == src_b[WIDTH-1] && sum[WIDTH-1] != src_a[WIDTH-1]) :
                     op == 4'd1 ? (src_a[WIDTH-1] != src_b[WIDTH-1] && dif[WIDTH-1] != src_a[WIDTH-1]) : 1'b0;

    // One iteration step: shift-add for MUL, restoring subtract for DIV (quotient shifts into lo)
    assign mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, mag} : '0);
    assign r_sh    = {acc, lo[WIDTH-1]};
    assign r_dif   = r_sh - {1'b0, mag};
    assign step_hi = state == DIV ? (r_dif[WIDTH] ? r_sh[WIDTH-1:0] : r_dif[WIDTH-1:0]) : mul_sum[WIDTH:1];
    assign step_lo = state == DIV ? {lo[WIDTH-2:0], ~r_dif[WIDTH]} : {mul_sum[0], lo[WIDTH-1:1]};
    assign last    = cnt + 1'b1 == (SHW+1)'(WIDTH);
    assign neg     = sign_a ^ sign_b;
    assign prod    = {step_hi, step_lo};
    assign prod_s  = neg ? -prod : prod;
    assign fin_lo  = is_div ? (neg ? -step_lo : step_lo) : prod_s[WIDTH-1:0];
    assign fin_hi  = is_div ? (sign_a ? -step_hi : step_hi) : prod_s[2*WIDTH-1:WIDTH];

    always_comb begin
        state_n = state;
        if (idle)
            state_n = (take && op_mul) ? MUL : (take && op_div) ? DIV : IDLE;
        else if (last)
            state_n = FIN;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            acc       <= '0;
            lo        <= '0;
            mag       <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            is_div    <= 1'b0;
            ovf_p     <= 1'b0;
            eq_p      <= 1'b0;
            gt_p      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            div_zero  <= 1'b0;
            eq        <= 1'b0;
            gt        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (take) begin
                cnt    <= '0;
                acc    <= '0;
                lo     <= op_mul ? abs_b : abs_a;
                mag    <= op_mul ? abs_a : abs_b;
                sign_a <= src_a[WIDTH-1];
                sign_b <= src_b[WIDTH-1];
                is_div <= op == 4'd12;
                ovf_p  <= src_a == MIN && src_b == '1;
                eq_p   <= src_a == src_b;
                gt_p   <= cmp_gt;
                if (!op_mul && !op_div) begin
                    done      <= 1'b1;
                    result    <= alu;
                    result_hi <= div0 ? src_a : '0;
                    overflow  <= alu_ovf;
                    zero      <= !rsv && alu == '0;
                    div_zero  <= div0;
                    eq        <= !rsv && src_a == src_b;
                    gt        <= !rsv && cmp_gt;
                end
            end else if (busy) begin
                cnt <= cnt + 1'b1;
                acc <= step_hi;
                lo  <= step_lo;
                if (last) begin
                    done      <= 1'b1;
                    result    <= fin_lo;
                    result_hi <= fin_hi;
                    overflow  <= is_div && ovf_p;
                    zero      <= fin_lo == '0;
                    div_zero  <= 1'b0;
                    eq        <= eq_p;
                    gt        <= gt_p;
                end
            end
        end
    end
endmodule

// File: tb/tb_exec_unit_mc.sv
// tb_exec_unit_mc: directed checks of exec_unit_mc at WIDTH=32 and WIDTH=16.
module tb_exec_unit_mc;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic st = 1'b0, st16 = 1'b0;
    logic [3:0] opc = '0, opc16 = '0;
    logic [31:0] sa = '0, sb = '0;
    logic [15:0] sa16 = '0, sb16 = '0;
    logic [4:0] sh = '0;
    logic [3:0] sh16 = '0;
    logic busy, done, ovf, zf, dz, eqf, gtf;
    logic [31:0] res, hi;
    logic busy16, done16, ovf16, zf16, dz16, eqf16, gtf16;
    logic [15:0] res16, hi16;
    int errors = 0, checks = 0;
    int lat, bz;

    always #5 clk = ~clk;

    exec_unit_mc #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(st), .op(opc), .src_a(sa), .src_b(sb), .shamt(sh),
        .busy(busy), .done(done), .result(res), .result_hi(hi), .overflow(ovf), .zero(zf),
        .div_zero(dz), .eq(eqf), .gt(gtf));

    exec_unit_mc #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(st16), .op(opc16), .src_a(sa16), .src_b(sb16), .shamt(sh16),
        .busy(busy16), .done(done16), .result(res16), .result_hi(hi16), .overflow(ovf16), .zero(zf16),
        .div_zero(dz16), .eq(eqf16), .gt(gtf16));

    task automatic go32(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] s);
        opc = o; sa = x; sb = y; sh = s; st = 1'b1;
        @(posedge clk); #1;
        st = 1'b0;
        lat = 1; bz = 0;
        while (!done && lat < 100) begin
            bz += int'(busy);
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic go16(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
        opc16 = o; sa16 = x; sb16 = y; sh16 = '0; st16 = 1'b1;
        @(posedge clk); #1;
        st16 = 1'b0;
        lat = 1; bz = 0;
        while (!done16 && lat < 100) begin
            bz += int'(busy16);
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        if ({busy, done, ovf, zf, dz, eqf, gtf} !== 7'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000000", {busy, done, ovf, zf, dz, eqf, gtf}); end checks++;
        if ({res, hi} !== 64'h0) begin errors++; $display("FAIL reset_results: got %h expected 0", {res, hi}); end checks++;
        if ({busy16, done16, res16, hi16} !== 34'h0) begin errors++; $display("FAIL reset_w16: got %h expected 0", {busy16, done16, res16, hi16}); end checks++;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_sub();
        go32(4'd0, 32'h7FFFFFFF, 32'h00000001, 5'd0);
        if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d expected 1", lat); end checks++;
        if (res !== 32'h80000000) begin errors++; $display("FAIL add_result: got %h expected 80000000", res); end checks++;
        if ({ovf, zf, hi} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL add_flags: got ovf=%b zero=%b hi=%h expected 1 0 0", ovf, zf, hi); end checks++;
        go32(4'd1, 32'd5, 32'd5, 5'd0);
        if (res !== 32'h0) begin errors++; $display("FAIL sub_result: got %h expected 0", res); end checks++;
        if ({zf, eqf, gtf, ovf} !== 4'b1100) begin errors++; $display("FAIL sub_flags: got %b expected 1100", {zf, eqf, gtf, ovf}); end checks++;
    endtask

    task automatic test_mult();
        go32(4'd11, 32'hFFFFFFFD, 32'd7, 5'd0);
        if (lat !== 33 || bz !== 32) begin errors++; $display("FAIL mult_timing: got lat=%0d busy=%0d expected 33 32", lat, bz); end checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy_at_done: got %b expected 0", busy); end checks++;
        if ({hi, res} !== 64'hFFFFFFFF_FFFFFFEB) begin errors++; $display("FAIL mult_neg: got %h expected ffffffffffffffeb", {hi, res}); end checks++;
        go32(4'd11, 32'h80000000, 32'h80000000, 5'd0);
        if ({hi, res} !== 64'h40000000_00000000) begin errors++; $display("FAIL mult_min: got %h expected 4000000000000000", {hi, res}); end checks++;
        if ({ovf, zf, eqf} !== 3'b011) begin errors++; $display("FAIL mult_min_flags: got %b expected 011", {ovf, zf, eqf}); end checks++;
    endtask

    task automatic test_div();
        go32(4'd12, 32'hFFFFFFF9, 32'd2, 5'd0);
        if (lat !== 33) begin errors++; $display("FAIL div_latency: got %0d expected 33", lat); end checks++;
        if ({res, hi} !== {32'hFFFFFFFD, 32'hFFFFFFFF}) begin errors++; $display("FAIL div_neg: got q=%h r=%h expected fffffffd ffffffff", res, hi); end checks++;
        go32(4'd12, 32'h80000000, 32'hFFFFFFFF, 5'd0);
        if ({res, hi} !== {32'h80000000, 32'h0}) begin errors++; $display("FAIL div_min: got q=%h r=%h expected 80000000 0", res, hi); end checks++;
        if ({ovf, dz} !== 2'b10) begin errors++; $display("FAIL div_min_flags: got %b expected 10", {ovf, dz}); end checks++;
        go32(4'd12, 32'd100, 32'd7, 5'd0);
        if ({res, hi, ovf, gtf} !== {32'd14, 32'd2, 1'b0, 1'b1}) begin errors++; $display("FAIL div_pos: got q=%h r=%h ovf=%b gt=%b expected e 2 0 1", res, hi, ovf, gtf); end checks++;
    endtask

    task automatic test_div_zero();
        go32(4'd12, 32'd9, 32'd0, 5'd0);
        if (lat !== 1 || bz !== 0 || busy !== 1'b0) begin errors++; $display("FAIL divz_timing: got lat=%0d busy=%0d expected 1 0", lat, bz); end checks++;
        if ({res, hi} !== {32'hFFFFFFFF, 32'd9}) begin errors++; $display("FAIL divz_result: got %h %h expected ffffffff 9", res, hi); end checks++;
        if ({dz, ovf, gtf} !== 3'b101) begin errors++; $display("FAIL divz_flags: got %b expected 101", {dz, ovf, gtf}); end checks++;
    endtask

    task automatic test_shift_misc();
        go32(4'd8, 32'h0, 32'h80000000, 5'd4);
        if (res !== 32'hF8000000) begin errors++; $display("FAIL sra: got %h expected f8000000", res); end checks++;
        go32(4'd10, 32'h24, 32'h80000000, 5'd0);
        if (res !== 32'hF8000000) begin errors++; $display("FAIL srav: got %h expected f8000000", res); end checks++;
        go32(4'd9, 32'h3, 32'h1, 5'd7);
        if (res !== 32'h8) begin errors++; $display("FAIL sllv: got %h expected 8", res); end checks++;
        go32(4'd7, 32'h0, 32'h80000000, 5'd4);
        if (res !== 32'h08000000) begin errors++; $display("FAIL srl: got %h expected 08000000", res); end checks++;
        go32(4'd5, 32'hFFFFFFFF, 32'd1, 5'd0);
        if ({res, gtf} !== {32'd1, 1'b0}) begin errors++; $display("FAIL slt: got %h gt=%b expected 1 0", res, gtf); end checks++;
        go32(4'd14, 32'd5, 32'd5, 5'd0);
        if ({res, hi, ovf, zf, dz, eqf, gtf} !== 69'h0) begin errors++; $display("FAIL reserved: got res=%h flags=%b expected 0", res, {ovf, zf, dz, eqf, gtf}); end checks++;
        go32(4'd13, 32'h1234ABCD, 32'd0, 5'd0);
        if ({res, hi} !== {32'h1234ABCD, 32'h0}) begin errors++; $display("FAIL passa: got %h %h expected 1234abcd 0", res, hi); end checks++;
    endtask

    task automatic test_back_to_back();
        go32(4'd11, 32'hFFFFFFFD, 32'd7, 5'd0);
        go32(4'd0, 32'd2, 32'd3, 5'd0);
        if (lat !== 1 || res !== 32'd5 || hi !== 32'h0) begin errors++; $display("FAIL b2b_add: got lat=%0d res=%h hi=%h expected 1 5 0", lat, res, hi); end checks++;
        @(posedge clk); #1;
        if (done !== 1'b0 || res !== 32'd5) begin errors++; $display("FAIL done_pulse_hold: got done=%b res=%h expected 0 5", done, res); end checks++;
    endtask

    task automatic test_ignore_start();
        opc = 4'd11; sa = 32'd2; sb = 32'd3; st = 1'b1;
        @(posedge clk); #1;
        st = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            if (lat == 5) begin opc = 4'd0; sa = 32'd100; sb = 32'd100; st = 1'b1; end
            else st = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        st = 1'b0;
        if (lat !== 33 || res !== 32'd6 || eqf !== 1'b0) begin errors++; $display("FAIL ignore_start: got lat=%0d res=%h eq=%b expected 33 6 0", lat, res, eqf); end checks++;
        @(posedge clk); #1;
        if (done !== 1'b0) begin errors++; $display("FAIL ignore_no_extra_done: got %b expected 0", done); end checks++;
    endtask

    task automatic test_reset_abort();
        int seen;
        opc = 4'd11; sa = 32'd9; sb = 32'd9; st = 1'b1;
        @(posedge clk); #1;
        st = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b expected 1", busy); end checks++;
        reset = 1'b0;
        #1;
        if ({busy, done, res, hi, ovf, zf, dz, eqf, gtf} !== 71'h0) begin errors++; $display("FAIL abort_outputs: got busy=%b res=%h hi=%h", busy, res, hi); end checks++;
        @(posedge clk); #1;
        reset = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            seen += int'(done) + int'(busy);
        end
        if (seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles expected 0", seen); end checks++;
        go32(4'd0, 32'd1, 32'd1, 5'd0);
        if (lat !== 1 || res !== 32'd2) begin errors++; $display("FAIL abort_then_add: got lat=%0d res=%h expected 1 2", lat, res); end checks++;
    endtask

    task automatic test_width16();
        go16(4'd0, 16'h7FFF, 16'h0001);
        if ({lat, res16, ovf16} !== {32'd1, 16'h8000, 1'b1}) begin errors++; $display("FAIL w16_add: got lat=%0d res=%h ovf=%b expected 1 8000 1", lat, res16, ovf16); end checks++;
        go16(4'd11, 16'hFFFD, 16'd7);
        if (lat !== 17 || bz !== 16) begin errors++; $display("FAIL w16_mult_timing: got lat=%0d busy=%0d expected 17 16", lat, bz); end checks++;
        if ({hi16, res16} !== 32'hFFFF_FFEB) begin errors++; $display("FAIL w16_mult: got %h expected ffffffeb", {hi16, res16}); end checks++;
        go16(4'd12, 16'hFFF9, 16'd2);
        if (lat !== 17 || {res16, hi16} !== 32'hFFFD_FFFF) begin errors++; $display("FAIL w16_div: got lat=%0d q=%h r=%h expected 17 fffd ffff", lat, res16, hi16); end checks++;
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mult();
        test_div();
        test_div_zero();
        test_shift_misc();
        test_back_to_back();
        test_ignore_start();
        test_reset_abort();
        test_width16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
